tl_cntr_timed: RTL

Moore-type two-street traffic-light controller: the next-state logic, 2-bit state register, dwell counter and output decoder. It consumes the car sensors, produces the light codes, and exports the current state code for the state-register and debug paths. Green phases are held for a minimum dwell, and yellow phases for a fixed dwell, both set by parameters.

---
 rtl/tl_cntr_timed.sv | 79 +++++++
 1 files changed

// File: rtl/tl_cntr_timed.sv
// Two-street Moore traffic-light controller with a saturating dwell counter.
// Greens are held for at least MIN_GREEN cycles and until their own sensor
// clears; yellows last exactly YELLOW_CYCLES cycles.
module tl_cntr_timed #(
    parameter int unsigned MIN_GREEN     = 8,
    parameter int unsigned YELLOW_CYCLES = 5,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S0 = 2'b00,   // A green,  B red
        S1 = 2'b01,   // A yellow, B red
        S2 = 2'b10,   // A red,    B green
        S3 = 2'b11    // A red,    B yellow
    } state_t;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;

    // State register and dwell counter; counter restarts on every state change
    // and sticks at all-ones so long greens never wrap back below GREEN_LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state logic: greens wait for min dwell and an idle own sensor,
    // yellows advance purely on time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: if (cnt >= GREEN_LAST && !Ta) state_d = S1;
            S1: if (cnt == YELLOW_LAST)       state_d = S2;
            S2: if (cnt >= GREEN_LAST && !Tb) state_d = S3;
            S3: if (cnt == YELLOW_LAST)       state_d = S0;
            default:                          state_d = S0;
        endcase
    end

    // Output decode from the registered state only (Moore).
    always_comb begin
        La    = RED;
        Lb    = RED;
        state = state_q;
        unique case (state_q)
            S0: begin La = GREEN;  Lb = RED;    end
            S1: begin La = YELLOW; Lb = RED;    end
            S2: begin La = RED;    Lb = GREEN;  end
            S3: begin La = RED;    Lb = YELLOW; end
            default: begin La = RED; Lb = RED; end
        endcase
    end

endmodule
